// File: rtl/vp_controller_if.sv
// Load-request / D-cache-return / prediction-result bundle for the value-prediction controller.
// Master drives loads and returns; slave (controller) drives prediction and resolution pulses.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface vp_controller_if;
    logic                   vp_en;
    logic                   ld_req_valid;
    logic [`ADDR_WIDTH-1:0] ld_req_pc;
    logic                   ld_req_ready;
    logic                   dc_valid;
    logic [`DATA_WIDTH-1:0] dc_data;
    logic                   pred_valid;
    logic [`DATA_WIDTH-1:0] pred_data;
    logic                   stall;
    logic                   res_valid;
    logic [`DATA_WIDTH-1:0] res_data;
    logic                   en_recover;
    logic                   correct_prediction;

    modport master (
        output vp_en, ld_req_valid, ld_req_pc, dc_valid, dc_data,
        input  ld_req_ready, pred_valid, pred_data, stall,
               res_valid, res_data, en_recover, correct_prediction
    );

    modport slave (
        input  vp_en, ld_req_valid, ld_req_pc, dc_valid, dc_data,
        output ld_req_ready, pred_valid, pred_data, stall,
               res_valid, res_data, en_recover, correct_prediction
    );
endinterface

// File: rtl/vp_controller.sv
// Last-value load predictor: one load in flight, speculates when the entry's confidence is saturated.
// Pulses appear one cycle after accept/return; only accepts loads in IDLE, stalls while waiting or recovering.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module vp_controller #(
    parameter int INDEX_WIDTH = 6,
    parameter int CONF_BITS   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    vp_controller_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_WIDTH;
    localparam logic [CONF_BITS-1:0] CONF_MAX = '1;

    typedef enum logic [1:0] {IDLE, SPEC, WAIT, RECOVER} state_t;

    state_t state, state_nxt;

    logic [`DATA_WIDTH-1:0] val_mem  [ENTRIES];
    logic [CONF_BITS-1:0]   conf_mem [ENTRIES];

    logic [INDEX_WIDTH-1:0] idx_q;
    logic [INDEX_WIDTH-1:0] req_idx;
    logic                   predict_ok;
    logic                   accept;
    logic                   resolve;
    logic                   hit;
    logic                   ready;
    logic                   stall;

    logic                   pred_valid_q;
    logic [`DATA_WIDTH-1:0] pred_data_q;
    logic                   res_valid_q;
    logic [`DATA_WIDTH-1:0] res_data_q;
    logic                   en_recover_q;
    logic                   correct_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.ld_req_pc[`ADDR_WIDTH-1:INDEX_WIDTH+2], bus.ld_req_pc[1:0]};

    assign req_idx    = bus.ld_req_pc[INDEX_WIDTH+1:2];
    assign predict_ok = bus.vp_en && (conf_mem[req_idx] == CONF_MAX);
    assign accept     = (state == IDLE) && bus.ld_req_valid;
    assign resolve    = bus.dc_valid && ((state == SPEC) || (state == WAIT));
    // SPEC verifies against the value actually handed out; WAIT trains against the stored entry.
    assign hit = (state == SPEC) ? (bus.dc_data == pred_data_q)
                                 : (bus.dc_data == val_mem[idx_q]);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.ld_req_valid) state_nxt = predict_ok ? SPEC : WAIT;
            SPEC:    if (bus.dc_valid)     state_nxt = hit ? IDLE : RECOVER;
            WAIT:    if (bus.dc_valid)     state_nxt = IDLE;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        stall = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            WAIT:    stall = 1'b1;
            RECOVER: stall = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_data_q  <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            en_recover_q <= 1'b0;
            correct_q    <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                val_mem[i]  <= '0;
                conf_mem[i] <= '0;
            end
        end else begin
            pred_valid_q <= accept && predict_ok;
            res_valid_q  <= resolve;
            en_recover_q <= resolve && (state == SPEC) && !hit;
            correct_q    <= resolve && (state == SPEC) && hit;
            if (accept) idx_q <= req_idx;
            if (accept && predict_ok) pred_data_q <= val_mem[req_idx];
            if (resolve) begin
                res_data_q <= bus.dc_data;
                if (hit) begin
                    if (conf_mem[idx_q] != CONF_MAX) conf_mem[idx_q] <= conf_mem[idx_q] + 1'b1;
                end else begin
                    val_mem[idx_q]  <= bus.dc_data;
                    conf_mem[idx_q] <= '0;
                end
            end
        end
    end

    assign bus.ld_req_ready       = ready;
    assign bus.stall              = stall;
    assign bus.pred_valid         = pred_valid_q;
    assign bus.pred_data          = pred_data_q;
    assign bus.res_valid          = res_valid_q;
    assign bus.res_data           = res_data_q;
    assign bus.en_recover         = en_recover_q;
    assign bus.correct_prediction = correct_q;
endmodule

// File: tb/tb_vp_controller.sv
// Bench for vp_controller: directed vector table, hand-written corner sequences, and
// random loads checked against a per-entry last-value/confidence model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_vp_controller;
    localparam int IW    = 6;
    localparam int CB    = 2;
    localparam int NENT  = 1 << IW;
    localparam int CMAX  = (1 << CB) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vp_controller_if vif();

    vp_controller #(.INDEX_WIDTH(IW), .CONF_BITS(CB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic [31:0] data;
        int          gap;
        logic        noise;
        logic        pred;
        logic [31:0] pdata;
        logic        corr;
        logic        rec;
    } vec_t;

    typedef struct {
        logic        pred;
        logic [31:0] pdata;
        logic        corr;
        logic        rec;
    } exp_t;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_val  [NENT];
    int          m_conf [NENT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_val[i]  = '0;
            m_conf[i] = 0;
        end
    endfunction

    // A load speculates iff enabled and confident; its return either confirms the
    // remembered value (confidence up) or replaces it (confidence back to zero).
    function automatic exp_t model_step(input logic [31:0] pc, input logic en, input logic [31:0] d);
        exp_t e;
        int i;
        i       = int'(pc[IW+1:2]);
        e.pred  = en && (m_conf[i] == CMAX);
        e.pdata = m_val[i];
        if (d == m_val[i]) begin
            e.corr = e.pred;
            e.rec  = 1'b0;
            if (m_conf[i] < CMAX) m_conf[i] = m_conf[i] + 1;
        end else begin
            e.corr    = 1'b0;
            e.rec     = e.pred;
            m_val[i]  = d;
            m_conf[i] = 0;
        end
        return e;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"},      32'(vif.ld_req_ready), 32'd1);
        chk({tag, "_stall"},      32'(vif.stall), 32'd0);
        chk({tag, "_pred_valid"}, 32'(vif.pred_valid), 32'd0);
        chk({tag, "_res_valid"},  32'(vif.res_valid), 32'd0);
        chk({tag, "_recover"},    32'(vif.en_recover), 32'd0);
        chk({tag, "_correct"},    32'(vif.correct_prediction), 32'd0);
        chk({tag, "_pred_data"},  vif.pred_data, 32'd0);
        chk({tag, "_res_data"},   vif.res_data, 32'd0);
    endtask

    // Issues one load and its return; called and returning on a negedge.
    task automatic do_load(input logic [31:0] pc, input logic en, input logic [31:0] d,
                           input int gap, input logic noise, input logic e_pred,
                           input logic [31:0] e_pdata, input logic e_corr, input logic e_rec);
        int w;
        w = 0;
        while (!vif.ld_req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_load", 32'(vif.ld_req_ready), 32'd1);
        vif.vp_en        = en;
        vif.ld_req_valid = 1'b1;
        vif.ld_req_pc    = pc;
        @(negedge clk);
        vif.ld_req_valid = 1'b0;
        vif.vp_en        = 1'b0;
        chk("pred_valid", 32'(vif.pred_valid), 32'(e_pred));
        if (e_pred) chk("pred_data", vif.pred_data, e_pdata);
        chk("stall_inflight", 32'(vif.stall), 32'(!e_pred));
        chk("ready_inflight", 32'(vif.ld_req_ready), 32'd0);
        for (int c = 1; c < gap; c++) begin
            if (noise) begin
                vif.ld_req_valid = 1'b1;
                vif.ld_req_pc    = pc ^ 32'h20;
            end
            @(negedge clk);
            chk("pred_pulse_width", 32'(vif.pred_valid), 32'd0);
            chk("res_early", 32'(vif.res_valid), 32'd0);
        end
        vif.ld_req_valid = 1'b0;
        vif.dc_valid     = 1'b1;
        vif.dc_data      = d;
        @(negedge clk);
        vif.dc_valid = 1'b0;
        chk("res_valid", 32'(vif.res_valid), 32'd1);
        chk("res_data", vif.res_data, d);
        chk("correct_prediction", 32'(vif.correct_prediction), 32'(e_corr));
        chk("en_recover", 32'(vif.en_recover), 32'(e_rec));
        if (e_rec) begin
            chk("stall_recover", 32'(vif.stall), 32'd1);
            chk("ready_recover", 32'(vif.ld_req_ready), 32'd0);
            @(negedge clk);
            chk("recover_pulse_width", 32'(vif.en_recover), 32'd0);
        end
        chk("res_pulse_width_or_idle", 32'(vif.ld_req_ready), 32'd1);
        chk("stall_idle", 32'(vif.stall), 32'd0);
    endtask

    task automatic model_load(input logic [31:0] pc, input logic en, input logic [31:0] d,
                              input int gap, input logic noise);
        exp_t e;
        e = model_step(pc, en, d);
        do_load(pc, en, d, gap, noise, e.pred, e.pdata, e.corr, e.rec);
    endtask

    vec_t tbl[13];

    initial begin
        vif.vp_en        = 1'b0;
        vif.ld_req_valid = 1'b0;
        vif.ld_req_pc    = '0;
        vif.dc_valid     = 1'b0;
        vif.dc_data      = '0;

        //          pc        en    data        gap noise pred  pdata       corr  rec
        tbl[0]  = '{32'h040, 1'b1, 32'h1234, 2, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[1]  = '{32'h040, 1'b1, 32'h1234, 1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[2]  = '{32'h040, 1'b1, 32'h1234, 3, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[3]  = '{32'h040, 1'b1, 32'h1234, 2, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[4]  = '{32'h040, 1'b1, 32'h1234, 2, 1'b0, 1'b1, 32'h1234, 1'b1, 1'b0};
        tbl[5]  = '{32'h040, 1'b1, 32'h5678, 1, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b1};
        tbl[6]  = '{32'h040, 1'b1, 32'h5678, 2, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[7]  = '{32'h040, 1'b1, 32'h5678, 2, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[8]  = '{32'h040, 1'b1, 32'h5678, 2, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[9]  = '{32'h040, 1'b0, 32'h5678, 2, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        tbl[10] = '{32'h040, 1'b1, 32'h5678, 2, 1'b0, 1'b1, 32'h5678, 1'b1, 1'b0};
        tbl[11] = '{32'h140, 1'b1, 32'h5678, 2, 1'b0, 1'b1, 32'h5678, 1'b1, 1'b0};
        tbl[12] = '{32'h040, 1'b1, 32'h5678, 3, 1'b1, 1'b1, 32'h5678, 1'b1, 1'b0};

        // reset values, during and after reset
        model_reset();
        repeat (2) @(negedge clk);
        chk_quiet("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("after_reset");

        foreach (tbl[k]) begin
            void'(model_step(tbl[k].pc, tbl[k].en, tbl[k].data));
            do_load(tbl[k].pc, tbl[k].en, tbl[k].data, tbl[k].gap, tbl[k].noise,
                    tbl[k].pred, tbl[k].pdata, tbl[k].corr, tbl[k].rec);
        end

        // stray return while idle must neither pulse nor touch the table
        vif.dc_valid = 1'b1;
        vif.dc_data  = 32'hdead;
        @(negedge clk);
        vif.dc_valid = 1'b0;
        chk("idle_dc_res_valid", 32'(vif.res_valid), 32'd0);
        chk("idle_dc_ready", 32'(vif.ld_req_ready), 32'd1);
        model_load(32'h040, 1'b1, 32'h5678, 2, 1'b0);
        // the noise request during the earlier load must not have allocated its entry
        model_load(32'h060, 1'b1, 32'h0, 2, 1'b0);

        // reset while speculating
        vif.vp_en        = 1'b1;
        vif.ld_req_valid = 1'b1;
        vif.ld_req_pc    = 32'h040;
        @(negedge clk);
        vif.ld_req_valid = 1'b0;
        chk("spec_before_reset", 32'(vif.pred_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_quiet("reset_in_spec");
        model_reset();
        model_load(32'h040, 1'b1, 32'h5678, 2, 1'b0);

        for (int t = 0; t < 200; t++) begin
            logic [31:0] pc;
            logic        en;
            pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 5)) << 2)
               | 32'($urandom_range(0, 3));
            en = ($urandom_range(0, 4) != 0);
            model_load(pc, en, 32'($urandom_range(1, 3)), $urandom_range(1, 3),
                       1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule
